// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: ID-stage resolution of RV64 conditional branches, JAL and JALR.
// It holds a PC-indexed 2-bit branch history table that fetch reads for predictions.
// It also drives a flush/redirect that lasts a fixed number of cycles and keeps
// saturating performance counters.
module branch_resolve_unit #(
  parameter int DATA_W    = 64,
  parameter int BHT_DEPTH = 16,
  parameter int FLUSH_LEN = 1,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fetch_pc,
  output logic              pred_taken,
  input  logic              valid_in,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] imm,
  input  logic              pred_taken_in,
  output logic              flush_o,
  output logic [DATA_W-1:0] redirect_pc_o,
  output logic              taken_o,
  output logic [CNT_W-1:0]  br_cnt_o,
  output logic [CNT_W-1:0]  mispred_cnt_o
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int FC_W  = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t            r_state;
  logic [FC_W-1:0]   r_fcnt;
  logic              r_flush;
  logic [DATA_W-1:0] r_redirect;
  logic              r_taken;
  logic [CNT_W-1:0]  r_br_cnt;
  logic [CNT_W-1:0]  r_mis_cnt;
  logic [1:0]        r_bht [BHT_DEPTH];

  logic              w_is_br;
  logic              w_is_jal;
  logic              w_is_jalr;
  logic              w_accept;
  logic              w_legal;
  logic              w_eq;
  logic              w_slt;
  logic              w_ult;
  logic              w_cond;
  logic              w_taken;
  logic              w_flush;
  logic [DATA_W-1:0] w_target;
  logic [DATA_W-1:0] w_pc_plus4;
  logic [DATA_W-1:0] w_br_tgt;
  logic [DATA_W-1:0] w_jalr_sum;
  logic              w_bht_we;
  logic [IDX_W-1:0]  w_upd_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [1:0]        w_bht_next [BHT_DEPTH];
  logic              w_unused;

  assign w_is_br   = (opcode == OP_BRANCH);
  assign w_is_jal  = (opcode == OP_JAL);
  assign w_is_jalr = (opcode == OP_JALR);
  // Instructions that arrive while a flush is in progress are on the wrong path, so only IDLE accepts.
  assign w_accept  = (r_state == S_IDLE) && valid_in && (w_is_br || w_is_jal || w_is_jalr);
  // funct3 values 010 and 011 are the two illegal branch encodings.
  assign w_legal   = (funct3[2:1] != 2'b01);

  assign w_eq       = (data1 == data2);
  assign w_slt      = ($signed(data1) < $signed(data2));
  assign w_ult      = (data1 < data2);
  assign w_pc_plus4 = pc_in + DATA_W'(4);
  assign w_br_tgt   = pc_in + imm;
  assign w_jalr_sum = data1 + imm;

  assign w_upd_idx  = pc_in[IDX_W+1:2];
  assign w_rd_idx   = fetch_pc[IDX_W+1:2];
  assign w_bht_we   = w_accept && w_is_br && w_legal;

  // Fetch sees the registered table, so a same-cycle update shows up only on the next cycle.
  assign pred_taken = r_bht[w_rd_idx][1];

  assign w_unused = ^{fetch_pc[DATA_W-1:IDX_W+2], fetch_pc[1:0], w_jalr_sum[0]};

  // Branch condition; illegal encodings resolve as not taken.
  always_comb begin
    w_cond = 1'b0;
    case (funct3)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = !w_eq;
      3'b100:  w_cond = w_slt;
      3'b101:  w_cond = !w_slt;
      3'b110:  w_cond = w_ult;
      3'b111:  w_cond = !w_ult;
      default: w_cond = 1'b0;
    endcase
  end

  // Resolved outcome, flush decision and redirect target of the ID-stage op.
  always_comb begin
    w_taken  = 1'b0;
    w_flush  = 1'b0;
    w_target = w_pc_plus4;
    if (w_is_br) begin
      w_taken = w_legal && w_cond;
      if (w_legal) begin
        w_flush  = (w_cond != pred_taken_in);
        w_target = w_cond ? w_br_tgt : w_pc_plus4;
      end else begin
        w_flush  = pred_taken_in;
        w_target = w_pc_plus4;
      end
    end else if (w_is_jal) begin
      w_taken  = 1'b1;
      w_flush  = !pred_taken_in;
      w_target = w_br_tgt;
    end else if (w_is_jalr) begin
      w_taken  = 1'b1;
      w_flush  = 1'b1;
      w_target = {w_jalr_sum[DATA_W-1:1], 1'b0};
    end
  end

  // Per-entry next value: a saturating 2-bit counter step on the addressed entry.
  for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
    logic w_hit;
    assign w_hit = w_bht_we && (w_upd_idx == IDX_W'(gi));
    assign w_bht_next[gi] = !w_hit ? r_bht[gi] :
                            w_taken ? ((r_bht[gi] == 2'b11) ? 2'b11 : r_bht[gi] + 2'd1) :
                                      ((r_bht[gi] == 2'b00) ? 2'b00 : r_bht[gi] - 2'd1);
  end

  // BHT storage; reset returns every entry to weakly not-taken.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BHT_DEPTH; i++) begin
      r_bht[i] <= rst ? 2'b01 : w_bht_next[i];
    end
  end

  // Control FSM: accept in IDLE, hold flush/redirect for FLUSH_LEN cycles in FLUSH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fcnt     <= '0;
      r_flush    <= 1'b0;
      r_redirect <= '0;
      r_taken    <= 1'b0;
      r_br_cnt   <= '0;
      r_mis_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_taken <= w_taken;
            if (w_bht_we && (r_br_cnt != '1)) r_br_cnt <= r_br_cnt + CNT_W'(1);
            if (w_flush) begin
              r_state    <= S_FLUSH;
              r_flush    <= 1'b1;
              r_redirect <= w_target;
              r_fcnt     <= FC_W'(FLUSH_LEN - 1);
              if (w_bht_we && (r_mis_cnt != '1)) r_mis_cnt <= r_mis_cnt + CNT_W'(1);
            end
          end
        end
        S_FLUSH: begin
          if (r_fcnt == '0) begin
            r_state <= S_IDLE;
            r_flush <= 1'b0;
          end else begin
            r_fcnt <= r_fcnt - FC_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign flush_o       = r_flush;
  assign redirect_pc_o = r_redirect;
  assign taken_o       = r_taken;
  assign br_cnt_o      = r_br_cnt;
  assign mispred_cnt_o = r_mis_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench: two instances (FLUSH_LEN=1 and 3, 4-bit counters) share one input set.
// Each instance has its own behavioural model of table, counters and flush countdown.
module tb_branch_resolve_unit;

  localparam int DW  = 64;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fetch_pc;
  logic          valid_in;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [DW-1:0] data1, data2, pc_in, imm;
  logic          pred_taken_in;

  logic          pred_v  [2];
  logic          flush_v [2];
  logic [DW-1:0] redir_v [2];
  logic          taken_v [2];
  logic [CW-1:0] br_v    [2];
  logic [CW-1:0] mis_v   [2];

  int checks = 0;
  int errors = 0;

  // Model state per instance
  int          m_len   [2] = '{1, 3};
  int          m_bht   [2][16];
  int          m_br    [2];
  int          m_mis   [2];
  int          m_rem   [2];
  logic        m_taken [2];
  logic [DW-1:0] m_redir [2];

  always #5 clk = ~clk;

  branch_resolve_unit #(.DATA_W(DW), .BHT_DEPTH(16), .FLUSH_LEN(1), .CNT_W(CW)) u_dut1 (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_v[0]),
    .valid_in(valid_in), .opcode(opcode), .funct3(funct3), .data1(data1), .data2(data2),
    .pc_in(pc_in), .imm(imm), .pred_taken_in(pred_taken_in), .flush_o(flush_v[0]),
    .redirect_pc_o(redir_v[0]), .taken_o(taken_v[0]), .br_cnt_o(br_v[0]), .mispred_cnt_o(mis_v[0]));

  branch_resolve_unit #(.DATA_W(DW), .BHT_DEPTH(16), .FLUSH_LEN(3), .CNT_W(CW)) u_dut3 (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_v[1]),
    .valid_in(valid_in), .opcode(opcode), .funct3(funct3), .data1(data1), .data2(data2),
    .pc_in(pc_in), .imm(imm), .pred_taken_in(pred_taken_in), .flush_o(flush_v[1]),
    .redirect_pc_o(redir_v[1]), .taken_o(taken_v[1]), .br_cnt_o(br_v[1]), .mispred_cnt_o(mis_v[1]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [DW-1:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  // Apply the RV64 rules to whatever was sampled at this edge.
  task automatic model_edge();
    logic t;
    logic legal;
    int   ix;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) m_bht[k][i] = 1;
        m_br[k] = 0; m_mis[k] = 0; m_rem[k] = 0; m_taken[k] = 1'b0; m_redir[k] = '0;
      end else if (m_rem[k] > 0) begin
        m_rem[k]--;
      end else if (valid_in && opcode == OP_BR) begin
        legal = !(funct3 == 3'd2 || funct3 == 3'd3);
        case (funct3)
          3'd0: t = (data1 == data2);
          3'd1: t = (data1 != data2);
          3'd4: t = ($signed(data1) < $signed(data2));
          3'd5: t = ($signed(data1) >= $signed(data2));
          3'd6: t = (data1 < data2);
          3'd7: t = (data1 >= data2);
          default: t = 1'b0;
        endcase
        if (!legal) begin
          m_taken[k] = 1'b0;
          if (pred_taken_in) begin m_rem[k] = m_len[k]; m_redir[k] = pc_in + 64'd4; end
        end else begin
          m_taken[k] = t;
          if (m_br[k] < CMAX) m_br[k]++;
          ix = idx_of(pc_in);
          if (t) m_bht[k][ix] = (m_bht[k][ix] == 3) ? 3 : m_bht[k][ix] + 1;
          else   m_bht[k][ix] = (m_bht[k][ix] == 0) ? 0 : m_bht[k][ix] - 1;
          if (t != pred_taken_in) begin
            m_rem[k] = m_len[k];
            m_redir[k] = t ? pc_in + imm : pc_in + 64'd4;
            if (m_mis[k] < CMAX) m_mis[k]++;
          end
        end
      end else if (valid_in && opcode == OP_JAL) begin
        m_taken[k] = 1'b1;
        if (!pred_taken_in) begin m_rem[k] = m_len[k]; m_redir[k] = pc_in + imm; end
      end else if (valid_in && opcode == OP_JALR) begin
        m_taken[k] = 1'b1;
        m_rem[k] = m_len[k];
        m_redir[k] = (data1 + imm) & ~64'd1;
      end
    end
  endtask

  // One clock: prediction checked before the edge, registered outputs after it.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      chk($sformatf("pred_taken[%0d]", k), 64'(pred_v[k]), 64'(m_bht[k][idx_of(fetch_pc)] >= 2));
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("flush_o[%0d]", k), 64'(flush_v[k]), 64'(m_rem[k] > 0));
      if (m_rem[k] > 0) chk($sformatf("redirect_pc_o[%0d]", k), redir_v[k], m_redir[k]);
      chk($sformatf("taken_o[%0d]", k), 64'(taken_v[k]), 64'(m_taken[k]));
      chk($sformatf("br_cnt_o[%0d]", k), 64'(br_v[k]), 64'(m_br[k]));
      chk($sformatf("mispred_cnt_o[%0d]", k), 64'(mis_v[k]), 64'(m_mis[k]));
    end
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic op(input logic [6:0] opc, input logic [2:0] f3, input logic [DW-1:0] d1,
                    input logic [DW-1:0] d2, input logic [DW-1:0] pc, input logic [DW-1:0] im,
                    input logic pr);
    valid_in = 1'b1; opcode = opc; funct3 = f3; data1 = d1; data2 = d2;
    pc_in = pc; imm = im; pred_taken_in = pr;
    tick();
    valid_in = 1'b0;
  endtask

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 4))
      0: return 64'd0;
      1: return 64'd5;
      2: return {DW{1'b1}};
      3: return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int s;
    rst = 1'b1; fetch_pc = 64'h40; valid_in = 1'b0; opcode = OP_ALU; funct3 = 3'd0;
    data1 = '0; data2 = '0; pc_in = '0; imm = '0; pred_taken_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) m_bht[k][i] = 1;
      m_br[k] = 0; m_mis[k] = 0; m_rem[k] = 0; m_taken[k] = 1'b0; m_redir[k] = '0;
    end

    // 1. reset state
    tick(); tick();
    rst = 1'b0;
    idle(1);
    chk("rst_pred", 64'(pred_v[0]), 64'd0);
    chk("rst_flush", 64'(flush_v[1]), 64'd0);
    chk("rst_redirect", redir_v[0], 64'd0);
    chk("rst_br_cnt", 64'(br_v[1]), 64'd0);

    // 2. taken BEQ predicted not-taken
    op(OP_BR, 3'd0, 64'd5, 64'd5, 64'h100, 64'h20, 1'b0);
    chk("t2_flush", 64'(flush_v[0]), 64'd1);
    chk("t2_redirect", redir_v[0], 64'h120);
    chk("t2_mispred", 64'(mis_v[0]), 64'd1);
    chk("t2_br", 64'(br_v[0]), 64'd1);
    fetch_pc = 64'h100;
    idle(4);
    chk("t2_bht0_msb", 64'(pred_v[1]), 64'd1);

    // 3. signed vs unsigned less-than
    op(OP_BR, 3'd4, {DW{1'b1}}, 64'd1, 64'h200, 64'h40, 1'b1);
    chk("t3_blt_noflush", 64'(flush_v[1]), 64'd0);
    chk("t3_blt_taken", 64'(taken_v[1]), 64'd1);
    idle(1);
    op(OP_BR, 3'd6, {DW{1'b1}}, 64'd1, 64'h200, 64'h40, 1'b1);
    chk("t3_bltu_flush", 64'(flush_v[1]), 64'd1);
    chk("t3_bltu_redirect", redir_v[1], 64'h204);
    idle(4);

    // 4. JALR, then a wrong-path branch in flush cycle 2
    op(OP_JALR, 3'd0, 64'h1003, 64'd0, 64'h300, 64'd0, 1'b1);
    chk("t4_redirect", redir_v[1], 64'h1002);
    idle(1);
    op(OP_BR, 3'd0, 64'd7, 64'd7, 64'h300, 64'h10, 1'b0);
    chk("t4_flush_len3_still_high", 64'(flush_v[1]), 64'd1);
    idle(4);

    // 5. saturate bht[2] with taken BEQs at pc 0x8, fetch reading the same entry
    fetch_pc = 64'h8;
    for (int i = 0; i < 4; i++) op(OP_BR, 3'd0, 64'd1, 64'd1, 64'h8, 64'h4, 1'b1);
    idle(1);
    chk("t5_bht2_msb", 64'(pred_v[0]), 64'd1);
    op(OP_BR, 3'd0, 64'd1, 64'd2, 64'h8, 64'h4, 1'b1);
    idle(4);
    chk("t5_bht2_after_dec", 64'(pred_v[1]), 64'd1);

    // 6. reset in flush cycle 1
    op(OP_JALR, 3'd0, 64'h2000, 64'd0, 64'h400, 64'd8, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_flush_cleared", 64'(flush_v[1]), 64'd0);
    chk("t6_bht_reset", 64'(pred_v[1]), 64'd0);
    idle(2);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      valid_in = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: opcode = OP_JAL;
        1: opcode = OP_JALR;
        2: opcode = OP_ALU;
        default: opcode = OP_BR;
      endcase
      funct3 = 3'($urandom_range(0, 7));
      data1 = pick();
      data2 = ($urandom_range(0, 2) == 0) ? data1 : pick();
      pc_in = 64'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 7) == 0) pc_in = {$urandom, $urandom};
      s = int'($urandom_range(0, 511)) - 256;
      imm = 64'(longint'(s));
      pred_taken_in = 1'($urandom_range(0, 1));
      fetch_pc = 64'($urandom_range(0, 63)) << 2;
      tick();
    end
    rst = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
